spmp_csr_bank: RTL and testbench

SPMP_CSR_BANK -- requirements
Module: spmp_csr_bank

---
 rtl/spmp_csr_bank_pkg.sv | 38 +++
 rtl/spmp_cfg_legalize.sv | 26 ++
 rtl/spmp_csr_bank.sv | 184 ++++++++++++++++++
 tb/tb_spmp_csr_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spmp_csr_bank_pkg.sv
// Shared SPMP definitions: cfg byte field offsets, A-field encodings, bank FSM
// states and the cfg write legalisation rule.
package spmp_csr_bank_pkg;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } spmp_a_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_FLUSH
  } spmp_state_e;

  // Reserved bits [6:5] read as zero; the W-without-R combination is illegal
  // and drops W.
  function automatic logic [7:0] legalize_cfg(input logic [7:0] w);
    logic [7:0] c;
    c                     = '0;
    c[CFG_L]              = w[CFG_L];
    c[CFG_A_HI:CFG_A_LO]  = w[CFG_A_HI:CFG_A_LO];
    c[CFG_X]              = w[CFG_X];
    c[CFG_W]              = w[CFG_W] & w[CFG_R];
    c[CFG_R]              = w[CFG_R];
    return c;
  endfunction

endpackage

// File: rtl/spmp_cfg_legalize.sv
// Combinational write legalisation and lock check for the entry addressed by
// the current request.
module spmp_cfg_legalize
  import spmp_csr_bank_pkg::*;
(
  input  logic [7:0] wdata,
  input  logic       cur_lock,
  input  logic       read_only,
  input  logic       nxt_exists,
  input  logic       nxt_lock,
  input  logic [1:0] nxt_a,
  output logic [7:0] legal_cfg,
  output logic       cfg_wr_ok,
  output logic       addr_wr_ok
);

  logic nxt_tor_lock;

  // A locked TOR entry above also freezes this entry's address, which is its base.
  assign nxt_tor_lock = nxt_exists && nxt_lock && (spmp_a_e'(nxt_a) == A_TOR);

  assign legal_cfg  = legalize_cfg(wdata);
  assign cfg_wr_ok  = !cur_lock && !read_only;
  assign addr_wr_ok = !cur_lock && !read_only && !nxt_tor_lock;

endmodule

// File: rtl/spmp_csr_bank.sv
// SPMP configuration/address register bank with a request/response port and a
// post-update flush window.
module spmp_csr_bank
  import spmp_csr_bank_pkg::*;
#(
  parameter int                             NrEntries   = 8,
  parameter int                             PLEN        = 56,
  parameter int                             FlushCycles = 2,
  parameter logic [NrEntries-1:0][7:0]      CfgRstVal   = '0,
  parameter logic [NrEntries-1:0][PLEN-3:0] AddrRstVal  = '0,
  parameter logic [NrEntries-1:0]           ReadOnly    = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_we_i,
  input  logic                             req_sel_i,
  input  logic [5:0]                       req_idx_i,
  input  logic [63:0]                      req_wdata_i,
  output logic                             rsp_valid_o,
  output logic [63:0]                      rsp_rdata_o,
  output logic                             rsp_err_o,
  output logic [NrEntries-1:0][7:0]        cfg_o,
  output logic [NrEntries-1:0][PLEN-3:0]   addr_o,
  output logic                             flush_o
);

  localparam int AddrW = PLEN - 2;

  logic [NrEntries-1:0][7:0]       cfg_reg;
  logic [NrEntries-1:0][AddrW-1:0] addr_reg;
  spmp_state_e                     state_reg;
  logic [3:0]                      cnt_reg;
  logic                            rsp_valid_reg;
  logic                            rsp_err_reg;
  logic [63:0]                     rsp_rdata_reg;
  logic                            flush_reg;
  logic                            changed_reg;

  logic             accept;
  logic             idx_ok;
  logic [7:0]       cur_cfg;
  logic [7:0]       nxt_cfg;
  logic [AddrW-1:0] cur_addr;
  logic [AddrW-1:0] wr_addr;
  logic             cur_ro;
  logic             nxt_exists;
  logic [7:0]       legal_cfg;
  logic             cfg_wr_ok;
  logic             addr_wr_ok;
  logic             cfg_we;
  logic             addr_we;
  logic             changed_next;
  logic [63:0]      rdata_next;
  logic             wdata_unused;

  assign req_ready_o  = (state_reg == ST_IDLE) && !rst_i;
  assign accept       = req_valid_i && req_ready_o;
  assign idx_ok       = 32'(req_idx_i) < 32'(NrEntries);
  assign wr_addr      = req_wdata_i[AddrW-1:0];
  assign wdata_unused = ^req_wdata_i[63:AddrW];

  // Selected entry and its upper neighbour; all zero when the index is out of range.
  always_comb begin
    cur_cfg    = '0;
    cur_addr   = '0;
    cur_ro     = 1'b0;
    nxt_cfg    = '0;
    nxt_exists = 1'b0;
    for (int i = 0; i < NrEntries; i++) begin
      if (req_idx_i == 6'(i)) begin
        cur_cfg  = cfg_reg[i];
        cur_addr = addr_reg[i];
        cur_ro   = ReadOnly[i];
      end
    end
    for (int i = 1; i < NrEntries; i++) begin
      if (req_idx_i == 6'(i - 1)) begin
        nxt_cfg    = cfg_reg[i];
        nxt_exists = 1'b1;
      end
    end
  end

  spmp_cfg_legalize u_legalize (
    .wdata      (req_wdata_i[7:0]),
    .cur_lock   (cur_cfg[CFG_L]),
    .read_only  (cur_ro),
    .nxt_exists (nxt_exists),
    .nxt_lock   (nxt_cfg[CFG_L]),
    .nxt_a      (nxt_cfg[CFG_A_HI:CFG_A_LO]),
    .legal_cfg  (legal_cfg),
    .cfg_wr_ok  (cfg_wr_ok),
    .addr_wr_ok (addr_wr_ok)
  );

  assign cfg_we  = accept && req_we_i && idx_ok && !req_sel_i && cfg_wr_ok;
  assign addr_we = accept && req_we_i && idx_ok &&  req_sel_i && addr_wr_ok;

  always_comb begin
    changed_next = (cfg_we && (legal_cfg != cur_cfg)) || (addr_we && (wr_addr != cur_addr));
    rdata_next   = '0;
    if (idx_ok) begin
      if (!req_sel_i) rdata_next = {56'd0, cfg_we ? legal_cfg : cur_cfg};
      else            rdata_next = 64'(addr_we ? wr_addr : cur_addr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_reg  <= CfgRstVal;
      addr_reg <= AddrRstVal;
    end else begin
      for (int i = 0; i < NrEntries; i++) begin
        if (req_idx_i == 6'(i)) begin
          if (cfg_we)  cfg_reg[i]  <= legal_cfg;
          if (addr_we) addr_reg[i] <= wr_addr;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      flush_reg     <= 1'b0;
      changed_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= !idx_ok;
            rsp_rdata_reg <= rdata_next;
            changed_reg   <= changed_next;
          end
        end
        ST_RESP: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
          changed_reg   <= 1'b0;
          if (changed_reg) begin
            state_reg <= ST_FLUSH;
            cnt_reg   <= 4'(FlushCycles);
            flush_reg <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (cnt_reg == 4'd1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            flush_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign flush_o     = flush_reg;

  for (genvar gi = 0; gi < NrEntries; gi++) begin : g_out
    assign cfg_o[gi]  = cfg_reg[gi];
    assign addr_o[gi] = addr_reg[gi];
  end

endmodule

// File: tb/tb_spmp_csr_bank.sv
// Directed bench for spmp_csr_bank with default parameters (8 entries,
// PLEN 56, two flush cycles, zero reset values).
module tb_spmp_csr_bank;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_sel;
  logic [5:0]        req_idx;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic [7:0][7:0]   cfg;
  logic [7:0][53:0]  addr;
  logic              flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spmp_csr_bank dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_sel_i   (req_sel),
    .req_idx_i   (req_idx),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .cfg_o       (cfg),
    .addr_o      (addr),
    .flush_o     (flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for ready, return #1 after the accept edge.
  task automatic send(input logic we, input logic sel, input logic [5:0] idx,
                      input logic [63:0] wd);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_sel   = sel;
    req_idx   = idx;
    req_wdata = wd;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    $display("req we=%0d sel=%0d idx=%0d wdata=0x%0h -> valid=%0d rdata=0x%0h err=%0d",
             we, sel, idx, wd, rsp_valid, rsp_rdata, rsp_err);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_sel   = 1'b0;
    req_idx   = '0;
    req_wdata = '0;
    step();
    step();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    chk("cfg_after_rst", cfg, 64'd0);

    // read of an untouched entry
    send(1'b0, 1'b0, 6'd3, 64'd0);
    chk("rd3_valid", 64'(rsp_valid), 64'd1);
    chk("rd3_rdata", rsp_rdata, 64'd0);
    chk("rd3_err", 64'(rsp_err), 64'd0);
    step();
    chk("rd3_valid_drop", 64'(rsp_valid), 64'd0);
    chk("rd3_no_flush", 64'(flush), 64'd0);
    chk("rd3_ready", 64'(req_ready), 64'd1);

    // state-changing cfg write followed by a 2-cycle flush
    send(1'b1, 1'b0, 6'd0, 64'h0F);
    chk("wr0_valid", 64'(rsp_valid), 64'd1);
    chk("wr0_rdata", rsp_rdata, 64'h0F);
    chk("wr0_cfg_o", 64'(cfg[0]), 64'h0F);
    chk("wr0_resp_noflush", 64'(flush), 64'd0);
    step();
    chk("wr0_flush1", 64'(flush), 64'd1);
    chk("wr0_flush1_ready", 64'(req_ready), 64'd0);
    chk("wr0_flush1_valid", 64'(rsp_valid), 64'd0);
    step();
    chk("wr0_flush2", 64'(flush), 64'd1);
    chk("wr0_flush2_ready", 64'(req_ready), 64'd0);
    step();
    chk("wr0_flush_end", 64'(flush), 64'd0);
    chk("wr0_ready_back", 64'(req_ready), 64'd1);

    // give entry 0 an address, then lock entry 1 as TOR above it
    send(1'b1, 1'b1, 6'd0, 64'hABC);
    chk("wa0_rdata", rsp_rdata, 64'hABC);
    chk("wa0_addr_o", 64'(addr[0]), 64'hABC);
    send(1'b1, 1'b0, 6'd1, 64'h8A);
    chk("wr1_rdata", rsp_rdata, 64'h88);
    chk("wr1_cfg_o", 64'(cfg[1]), 64'h88);
    send(1'b1, 1'b1, 6'd0, 64'h1234);
    chk("tor_lock_rdata", rsp_rdata, 64'hABC);
    chk("tor_lock_addr_o", 64'(addr[0]), 64'hABC);
    step();
    chk("tor_lock_noflush", 64'(flush), 64'd0);
    chk("tor_lock_ready", 64'(req_ready), 64'd1);
    send(1'b1, 1'b1, 6'd1, 64'h55);
    chk("lock_addr_rdata", rsp_rdata, 64'd0);
    send(1'b1, 1'b0, 6'd1, 64'h00);
    chk("lock_cfg_rdata", rsp_rdata, 64'h88);

    // W without R is dropped, reserved bits read zero
    send(1'b1, 1'b0, 6'd2, 64'h02);
    chk("wonly_rdata", rsp_rdata, 64'd0);
    chk("wonly_cfg_o", 64'(cfg[2]), 64'd0);
    step();
    chk("wonly_noflush", 64'(flush), 64'd0);
    send(1'b1, 1'b0, 6'd3, 64'hFF);
    chk("ff_rdata", rsp_rdata, 64'h9F);

    // out-of-range index
    send(1'b0, 1'b0, 6'd8, 64'd0);
    chk("oor_rd_err", 64'(rsp_err), 64'd1);
    chk("oor_rd_rdata", rsp_rdata, 64'd0);
    send(1'b1, 1'b0, 6'd8, 64'h07);
    chk("oor_wr_err", 64'(rsp_err), 64'd1);
    chk("oor_wr_rdata", rsp_rdata, 64'd0);
    step();
    chk("oor_noflush", 64'(flush), 64'd0);
    chk("cfg_snapshot", cfg, 64'h00000000_9F00880F);

    send(1'b0, 1'b1, 6'd0, 64'd0);
    chk("rd_addr0", rsp_rdata, 64'hABC);
    chk("rd_addr0_err", 64'(rsp_err), 64'd0);

    // reset in the middle of a flush
    send(1'b1, 1'b0, 6'd4, 64'h01);
    chk("wr4_rdata", rsp_rdata, 64'h01);
    step();
    chk("wr4_flush", 64'(flush), 64'd1);
    rst = 1'b1;
    step();
    chk("midrst_flush", 64'(flush), 64'd0);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("postrst_ready", 64'(req_ready), 64'd1);
    chk("postrst_cfg", cfg, 64'd0);
    chk("postrst_addr", 64'(|addr), 64'd0);
    step();
    chk("postrst_flush", 64'(flush), 64'd0);
    chk("postrst_valid", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
